// File: rtl/text_buffer.sv
// -----------------------------------------------------------------------------
// text_buffer
//
// Character-cell text buffer for a terminal-style display. An ASCII byte stream
// is accepted on a valid/ready handshake and written at a moving cursor. Any
// cell can be read back for the display through a registered read port.
//
// Control bytes handled by the writer:
//   0x20..0x7E : store at the cursor, then advance one cell
//   0x0A, 0x0D : move to column 0 of the next row (no cell written)
//   0x08       : step back one cell and blank it (no-op at (0,0))
//   0x0C       : blank the whole buffer (CLEAR state), cursor to (0,0)
//   others     : consumed, no effect
//
// After reset the FSM sweeps every cell to 0x20, one cell per cycle. wr_ready
// stays low for the whole sweep.
//
// Optional feature: define TEXT_BUFFER_CURSOR_BLINK_EN to enable the blinking
// cursor. While the blink phase is 1, a read of the cursor cell returns
// glyph 128 instead of the stored byte.
//
// Parameters:
//   ROW_NUMBER   - text lines (default 16)
//   COL_NUMBER   - characters per line (default 32)
//   BLINK_PERIOD - clock cycles per blink phase (default 50_000_000)
//
// Ports:
//   clk          in   1  clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   wr_valid     in   1  byte offered
//   wr_data      in   8  ASCII byte
//   wr_ready     out  1  high only in IDLE; the byte is taken when valid & ready
//   char_row     in   4  display read row
//   char_col     in   5  display read column
//   character_id out  8  glyph id for the row/column sampled on the previous edge
//   cursor_row   out  4  current write row
//   cursor_col   out  5  current write column
// -----------------------------------------------------------------------------
module text_buffer #(
    parameter int ROW_NUMBER   = 16,
    parameter int COL_NUMBER   = 32,
    parameter int BLINK_PERIOD = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    input  logic [3:0] char_row,
    input  logic [4:0] char_col,
    output logic [7:0] character_id,
    output logic [3:0] cursor_row,
    output logic [4:0] cursor_col
);

    localparam int              CELLS    = ROW_NUMBER * COL_NUMBER;
    localparam int              AW       = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [AW-1:0]   LAST     = AW'(CELLS - 1);
    localparam logic [3:0]      ROW_MAX  = 4'(ROW_NUMBER - 1);
    localparam logic [4:0]      COL_MAX  = 5'(COL_NUMBER - 1);
    localparam logic [7:0]      BLANK    = 8'h20;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    function automatic logic [AW-1:0] cell_addr(input logic [3:0] row, input logic [4:0] col);
        return AW'(int'(row) * COL_NUMBER + int'(col));
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        r_state;
    logic [AW-1:0] r_clr_addr;
    logic [3:0]    r_cur_row;
    logic [4:0]    r_cur_col;

    state_t        w_state_next;
    logic [AW-1:0] w_clr_next;
    logic [3:0]    w_row_next;
    logic [4:0]    w_col_next;

    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [7:0]    w_wdata;
    logic          w_ready;

    logic [AW-1:0] w_cur_addr;
    logic [3:0]    w_row_inc;
    logic          w_at_origin;

    assign w_cur_addr  = cell_addr(r_cur_row, r_cur_col);
    assign w_row_inc   = (r_cur_row == ROW_MAX) ? 4'd0 : r_cur_row + 4'd1;
    assign w_at_origin = (r_cur_row == 4'd0) && (r_cur_col == 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
            r_cur_row  <= 4'd0;
            r_cur_col  <= 5'd0;
        end else begin
            r_state    <= w_state_next;
            r_clr_addr <= w_clr_next;
            r_cur_row  <= w_row_next;
            r_cur_col  <= w_col_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clr_next   = r_clr_addr;
        w_row_next   = r_cur_row;
        w_col_next   = r_cur_col;
        w_we         = 1'b0;
        w_waddr      = w_cur_addr;
        w_wdata      = BLANK;
        w_ready      = 1'b0;

        case (r_state)
            S_CLEAR: begin
                w_we       = 1'b1;
                w_waddr    = r_clr_addr;
                w_row_next = 4'd0;
                w_col_next = 5'd0;
                if (r_clr_addr == LAST) begin
                    w_state_next = S_IDLE;
                    w_clr_next   = '0;
                end else begin
                    w_clr_next = r_clr_addr + 1'b1;
                end
            end

            S_IDLE: begin
                w_ready = 1'b1;
                if (wr_valid) begin
                    if (wr_data >= 8'h20 && wr_data <= 8'h7E) begin
                        w_we    = 1'b1;
                        w_wdata = wr_data;
                        if (r_cur_col == COL_MAX) begin
                            w_col_next = 5'd0;
                            w_row_next = w_row_inc;
                        end else begin
                            w_col_next = r_cur_col + 5'd1;
                        end
                    end else if (wr_data == 8'h0A || wr_data == 8'h0D) begin
                        w_col_next = 5'd0;
                        w_row_next = w_row_inc;
                    end else if (wr_data == 8'h08) begin
                        if (!w_at_origin) begin
                            // Cells are row-major, so one cell back is always
                            // the linear address minus one.
                            w_we    = 1'b1;
                            w_waddr = w_cur_addr - 1'b1;
                            if (r_cur_col == 5'd0) begin
                                w_col_next = COL_MAX;
                                w_row_next = r_cur_row - 4'd1;
                            end else begin
                                w_col_next = r_cur_col - 5'd1;
                            end
                        end
                    end else if (wr_data == 8'h0C) begin
                        w_state_next = S_CLEAR;
                        w_clr_next   = '0;
                        w_row_next   = 4'd0;
                        w_col_next   = 5'd0;
                    end
                end
            end

            default: begin
                w_state_next = S_CLEAR;
                w_clr_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Cell storage: single write port, registered read port. A read of
    // the cell being written in the same cycle returns the old contents.
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [CELLS];
    logic [7:0]    r_mem_q;
    logic          w_oob;
    logic [AW-1:0] w_raddr;
    logic          r_oob;
    logic [7:0]    w_cell;

    assign w_oob   = (int'(char_row) >= ROW_NUMBER) || (int'(char_col) >= COL_NUMBER);
    assign w_raddr = w_oob ? '0 : cell_addr(char_row, char_col);

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_mem_q <= r_mem[w_raddr];
    end

    // r_oob resets high so character_id shows a blank during and right
    // after reset, independent of the (unreset) RAM output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oob <= 1'b1;
        end else begin
            r_oob <= w_oob;
        end
    end

    assign w_cell = r_oob ? BLANK : r_mem_q;

`ifdef TEXT_BUFFER_CURSOR_BLINK_EN
    localparam int            BW       = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_PERIOD - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic [3:0]    r_rd_row;
    logic [4:0]    r_rd_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_rd_row      <= 4'd0;
            r_rd_col      <= 5'd0;
        end else begin
            r_rd_row <= char_row;
            r_rd_col <= char_col;
            if (r_blink_cnt == BLINK_TC) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign character_id = (r_blink_phase && r_rd_row == r_cur_row && r_rd_col == r_cur_col)
                          ? 8'd128 : w_cell;
`else
    assign character_id = w_cell;
`endif

    assign wr_ready   = w_ready;
    assign cursor_row = r_cur_row;
    assign cursor_col = r_cur_col;

endmodule

// File: tb/tb_text_buffer.sv
// -----------------------------------------------------------------------------
// tb_text_buffer
//
// Directed bench for text_buffer. Reads push their expected glyph into a
// scoreboard queue; a monitor forked alongside the stimulus pops and compares
// one cycle after each read address is presented. Handshake and cursor state
// are compared directly by the stimulus.
// -----------------------------------------------------------------------------
module tb_text_buffer;

`ifdef TEXT_BUFFER_CURSOR_BLINK_EN
    localparam int TB_BLINK = 4;
`else
    localparam int TB_BLINK = 50000000;
`endif

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [3:0] char_row;
    logic [4:0] char_col;
    logic [7:0] character_id;
    logic [3:0] cursor_row;
    logic [4:0] cursor_col;

    text_buffer #(
        .ROW_NUMBER  (16),
        .COL_NUMBER  (32),
        .BLINK_PERIOD(TB_BLINK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .char_row    (char_row),
        .char_col    (char_col),
        .character_id(character_id),
        .cursor_row  (cursor_row),
        .cursor_col  (cursor_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } rd_t;

    rd_t  sb_q[$];
    logic rd_req;
    int   n_checks;
    int   n_fail;
    int   exp_r;
    int   exp_c;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic v;
        rd_t  e;
        forever begin
            @(posedge clk);
            v = rd_req;
            @(negedge clk);
            if (v) begin
                if (sb_q.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk(e.name, int'(character_id), int'(e.exp));
                end
            end
        end
    endtask

    task automatic rd(input int r, input int c, input logic [7:0] exp);
        rd_t e;
`ifdef TEXT_BUFFER_CURSOR_BLINK_EN
        // The cursor cell may show the blink glyph; it is covered separately.
        if (r == exp_r && c == exp_c) return;
`endif
        char_row = 4'(r);
        char_col = 5'(c);
        e.exp    = exp;
        e.name   = $sformatf("cell(%0d,%0d)", r, c);
        sb_q.push_back(e);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic check_cursor(input string name, input int r, input int c);
        exp_r = r;
        exp_c = c;
        chk({name, "_row"}, int'(cursor_row), r);
        chk({name, "_col"}, int'(cursor_col), c);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n        = 0;
        wr_valid = 1'b1;
        wr_data  = b;
        while (!wr_ready && n < 2000) begin
            tick();
            n++;
        end
        if (!wr_ready) chk("send_timeout", 0, 1);
        tick();
        wr_valid = 1'b0;
        wr_data  = 8'h00;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!wr_ready && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic scan_all(input logic [7:0] exp);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 32; c++)
                rd(r, c, exp);
    endtask

    logic [7:0] row15 [32];

    initial begin
        int n;
        logic [7:0] s [16];

        n_checks = 0;
        n_fail   = 0;
        exp_r    = 0;
        exp_c    = 0;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        char_row = 4'd0;
        char_col = 5'd0;
        rd_req   = 1'b0;
        for (int i = 0; i < 32; i++)
            row15[i] = (i == 0) ? 8'h20 : (i == 31) ? 8'h7E : 8'(8'h40 + i);

        fork
            monitor();
        join_none

        // ---- reset state ----
        repeat (3) tick();
        chk("reset_wr_ready", int'(wr_ready), 0);
        chk("reset_character_id", int'(character_id), 8'h20);
        check_cursor("reset_cursor", 0, 0);

        rst_n = 1'b1;
        wait_ready(n);
        chk("init_clear_cycles", n, 512);
        check_cursor("after_init_cursor", 0, 0);
        scan_all(8'h20);

        // ---- two printable bytes ----
        send(8'h41);
        send(8'h42);
        check_cursor("after_AB", 0, 2);
        rd(0, 0, 8'h41);
        rd(0, 1, 8'h42);

        // ---- fill to end of row 0, then backspace across the row boundary ----
        repeat (29) send(8'h7A);
        check_cursor("end_row0", 0, 31);
        send(8'h51);
        check_cursor("after_Q", 1, 0);
        send(8'h08);
        check_cursor("bs_row_wrap", 0, 31);

        // ---- full last row wraps to (0,0) ----
        repeat (15) send(8'h0A);
        check_cursor("lf_to_row15", 15, 0);
        for (int i = 0; i < 32; i++) send(row15[i]);
        check_cursor("row15_wrap", 0, 0);

        // ---- line feed from the last row wraps to row 0 ----
        repeat (15) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'(8'h61 + i));
        check_cursor("at_15_5", 15, 5);
        send(8'h0A);
        check_cursor("lf_wrap", 0, 0);

        // ---- backspace at origin and ignored bytes ----
        send(8'h08);
        send(8'h07);
        send(8'h1F);
        send(8'h7F);
        check_cursor("noop_bytes", 0, 0);
        send(8'h0D);
        check_cursor("cr", 1, 0);

        rd(0, 0, 8'h41);
        rd(0, 1, 8'h42);
        rd(0, 2, 8'h7A);
        rd(0, 30, 8'h7A);
        rd(0, 31, 8'h20);
        rd(1, 1, 8'h20);
        for (int i = 0; i < 5; i++) rd(15, i, 8'(8'h61 + i));
        rd(15, 5, row15[5]);
        rd(15, 30, row15[30]);
        rd(15, 31, row15[31]);

        // ---- form feed clears everything ----
        send(8'h0C);
        chk("ff_ready_low", int'(wr_ready), 0);
        wait_ready(n);
        chk("ff_clear_cycles", n, 512);
        check_cursor("ff_cursor", 0, 0);
        scan_all(8'h20);

        // ---- reset in the middle of a clear restarts it ----
        send(8'h48);
        send(8'h0C);
        repeat (200) tick();
        rst_n = 1'b0;
        #1;
        chk("midclear_rst_ready", int'(wr_ready), 0);
        chk("midclear_rst_char", int'(character_id), 8'h20);
        tick();
        rst_n = 1'b1;
        wait_ready(n);
        chk("midclear_restart_cycles", n, 512);
        check_cursor("midclear_cursor", 0, 0);
        rd(0, 1, 8'h20);
        rd(15, 31, 8'h20);

        // ---- cursor cell readback ----
        send(8'h4B);
        check_cursor("after_K", 0, 1);
`ifdef TEXT_BUFFER_CURSOR_BLINK_EN
        char_row = 4'd0;
        char_col = 5'd1;
        tick();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s[i] = character_id;
        end
        tick();
        for (int i = 0; i < 16; i++)
            if (s[i] != 8'h20) chk($sformatf("blink_glyph[%0d]", i), int'(s[i]), 128);
        for (int i = 0; i < 12; i++)
            chk($sformatf("blink_toggle[%0d]", i), int'(s[i] != s[i+4]), 1);
`else
        for (int i = 0; i < 16; i++) s[i] = 8'h00;
        for (int i = 0; i < 12; i++) rd(0, 1, 8'h20);
`endif
        rd(0, 0, 8'h4B);

        // ---- drain the scoreboard ----
        repeat (3) tick();
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/text_buffer.md
TEXT_BUFFER -- requirements
Module: text_buffer

Interface
REQ-001 SHALL have parameter ROW_NUMBER, default 16, number of text lines.
REQ-002 SHALL have parameter COL_NUMBER, default 32, characters per line.
REQ-003 SHALL have parameter BLINK_PERIOD, default 50000000, clock cycles per cursor blink phase.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_valid  input  1  an input byte is offered.
REQ-007 SHALL have port wr_data  input  8  ASCII byte offered.
REQ-008 SHALL have port wr_ready  output  1  a byte is accepted when wr_valid and wr_ready are both high on a clock edge.
REQ-009 SHALL have port char_row  input  4  display row being read.
REQ-010 SHALL have port char_col  input  5  display column being read.
REQ-011 SHALL have port character_id  output  8  glyph id for (char_row, char_col).
REQ-012 SHALL have ports cursor_row (output, 4) and cursor_col (output, 5): current write position.

Function
REQ-013 SHALL store ROW_NUMBER*COL_NUMBER 8-bit cells, addressed row*COL_NUMBER+col.
REQ-014 SHALL register character_id: value reflects char_row/char_col sampled on the previous edge (1-cycle latency).
REQ-015 SHALL implement FSM with states CLEAR and IDLE; wr_ready = 1 only in IDLE.
REQ-016 In CLEAR, SHALL write 0x20 to one cell per cycle, ascending from address 0; after the last cell, SHALL go to IDLE on the next edge; cursor SHALL be (0,0) on entry to IDLE.
REQ-017 Accepted byte 0x20..0x7E SHALL be written at the cursor, then the cursor advances one column.
REQ-018 Column advance past COL_NUMBER-1 SHALL go to column 0 of the next row; past row ROW_NUMBER-1 SHALL wrap to row 0 (no scrolling).
REQ-019 Accepted 0x0A or 0x0D SHALL move the cursor to column 0 of the next row, wrapping row ROW_NUMBER-1 to 0; no cell is written.
REQ-020 Accepted 0x08 SHALL move the cursor back one cell (column 0 goes to column COL_NUMBER-1 of the previous row) and write 0x20 there; at (0,0) it SHALL do nothing.
REQ-021 Accepted 0x0C SHALL enter CLEAR; wr_ready SHALL be low from the next cycle.
REQ-022 Any other accepted byte SHALL be consumed with no effect.
REQ-023 A read of the cell written in the same cycle MAY return the old or new value; the next read SHALL return the new value.
REQ-024 char_row >= ROW_NUMBER or char_col >= COL_NUMBER SHALL return 0x20.

Reset
REQ-025 On rst_n low: FSM = CLEAR at address 0, cursor = (0,0), wr_ready = 0, character_id = 0x20, blink counter = 0, blink phase = 0.
REQ-026 Reset asserted mid-CLEAR or mid-operation SHALL restart the clear from address 0 after release; cell contents are not reset asynchronously.

Configuration
REQ-027 Macro TEXT_BUFFER_CURSOR_BLINK_EN SHALL enable the cursor blink feature.
REQ-028 With the macro defined: a counter SHALL toggle the blink phase every BLINK_PERIOD cycles; while the phase is 1 and the registered read address equals the cursor, character_id SHALL be 128 (cursor glyph) instead of the stored cell.
REQ-029 Without the macro: there is no blink counter, and character_id always equals the stored cell.

Verification
REQ-030 Reset release -> wr_ready low for exactly 512 cycles, then high; every cell reads 0x20; cursor (0,0).
REQ-031 Write 'A' (0x41) then 'B' (0x42) -> cell (0,0)=0x41, (0,1)=0x42, cursor (0,2); read of (0,1) shows 0x42 one cycle after the address is applied.
REQ-032 Write 32 printable bytes at row 15 starting at column 0 -> cursor (0,0); 0x0A at (15,5) -> cursor (0,0).
REQ-033 0x08 at (1,0) -> cursor (0,31), cell (0,31)=0x20; 0x08 at (0,0) -> no change; 0x07 -> no change.
REQ-034 0x0C after text -> wr_ready low for 512 cycles, all cells 0x20; rst_n pulsed at clear address 200 -> clear restarts, full 512-cycle wr_ready-low window.
REQ-035 TEXT_BUFFER_CURSOR_BLINK_EN with BLINK_PERIOD=4 -> read at the cursor alternates between the stored value and 128 every 4 cycles; without the macro it always returns the stored value.
